// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN     = 32;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_INC         = 4;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory handshake plus the held-instruction/redirect port to the core.
interface fetch_if #(
  parameter int unsigned XLEN = fetch_pkg::FETCH_XLEN
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic [XLEN-1:0] instr_pc_plus4;
  logic            instr_valid;
  logic            instr_ready;
  logic            pc_src;
  logic            target_sel;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jalr_target;
  logic            fetch_fault;

  modport master (
    output imem_req_valid, imem_addr, instr, instr_pc, instr_pc_plus4, instr_valid, fetch_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready, pc_src, target_sel,
           branch_target, jalr_target
  );

  modport slave (
    input  imem_req_valid, imem_addr, instr, instr_pc, instr_pc_plus4, instr_valid, fetch_fault,
    output imem_req_ready, imem_rsp_valid, imem_rdata, instr_ready, pc_src, target_sel,
           branch_target, jalr_target
  );

endinterface

// File: rtl/fetch_next_pc.sv
// Next-PC selection at retire: sequential +4 or redirect target (JALR bit 0 cleared).
// Misalignment detect output exists only with FETCH_MISALIGN_CHECK_EN.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = FETCH_XLEN
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_pc_src,
  input  logic            i_target_sel,
  input  logic [XLEN-1:0] i_branch_target,
  input  logic [XLEN-1:0] i_jalr_target,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            o_misaligned,
`endif
  output logic [XLEN-1:0] o_next_pc
);

  logic [XLEN-1:0] w_target;

  assign w_target  = i_target_sel ? {i_jalr_target[XLEN-1:1], 1'b0} : i_branch_target;
  assign o_next_pc = i_pc_src ? w_target : i_pc + XLEN'(PC_INC);

`ifdef FETCH_MISALIGN_CHECK_EN
  assign o_misaligned = i_pc_src && (w_target[1:0] != 2'b00);
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one imem request in flight, holds instr until retire.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
  input logic      clk,
  input logic      rst_n,
  fetch_if.master  bus
);

  fetch_state_e    r_state, w_state_next;
  logic [XLEN-1:0] r_pc, w_pc_next;
  logic [XLEN-1:0] r_instr, w_instr_next;
  logic [XLEN-1:0] r_instr_pc, w_instr_pc_next;
  logic [XLEN-1:0] w_retire_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            w_misaligned;
`endif

  fetch_next_pc #(
    .XLEN(XLEN)
  ) u_next_pc (
    .i_pc           (r_pc),
    .i_pc_src       (bus.pc_src),
    .i_target_sel   (bus.target_sel),
    .i_branch_target(bus.branch_target),
    .i_jalr_target  (bus.jalr_target),
`ifdef FETCH_MISALIGN_CHECK_EN
    .o_misaligned   (w_misaligned),
`endif
    .o_next_pc      (w_retire_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_instr_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_instr    <= w_instr_next;
      r_instr_pc <= w_instr_pc_next;
    end
  end

  // Responses outside WAIT are dropped; the PC only moves at retire, so it is stable in REQ.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_instr_next    = r_instr;
    w_instr_pc_next = r_instr_pc;
    case (r_state)
      StIdle: w_state_next = StReq;
      StReq: begin
        if (bus.imem_req_ready) w_state_next = StWait;
      end
      StWait: begin
        if (bus.imem_rsp_valid) begin
          w_instr_next    = bus.imem_rdata;
          w_instr_pc_next = r_pc;
          w_state_next    = StHold;
        end
      end
      StHold: begin
        if (bus.instr_ready) begin
          w_pc_next = w_retire_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
          w_state_next = w_misaligned ? StFault : StReq;
`else
          w_state_next = StReq;
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      StFault: w_state_next = StFault;
`endif
      default: w_state_next = StIdle;
    endcase
  end

  assign bus.imem_req_valid = (r_state == StReq);
  assign bus.imem_addr      = r_pc;
  assign bus.instr          = r_instr;
  assign bus.instr_pc       = r_instr_pc;
  assign bus.instr_pc_plus4 = r_instr_pc + XLEN'(PC_INC);
  assign bus.instr_valid    = (r_state == StHold);
`ifdef FETCH_MISALIGN_CHECK_EN
  assign bus.fetch_fault    = (r_state == StFault);
`else
  assign bus.fetch_fault    = 1'b0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-cycle RISC-V core. It owns the program counter, issues one instruction-memory request at a time over a valid/ready handshake, and holds the returned instruction stable for the datapath. When the controller retires that instruction, the unit uses the controller's branch/jump decision (`pc_src`) to select the next PC. It sits directly upstream of the controller and datapath and consumes the controller's `PCSrc` output.

## Interface
Parameters:
- `XLEN`, default 32: address and instruction width.
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.

Ports:
- `clk`, in, 1: sole clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `imem_req_valid`, out, 1: fetch request is valid.
- `imem_req_ready`, in, 1: instruction memory accepts the request.
- `imem_addr`, out, XLEN: fetch address (current PC).
- `imem_rsp_valid`, in, 1: instruction data is valid.
- `imem_rdata`, in, XLEN: instruction word.
- `instr`, out, XLEN: held instruction presented to the controller and datapath.
- `instr_pc`, out, XLEN: PC of `instr`.
- `instr_pc_plus4`, out, XLEN: `instr_pc` + 4, for JAL/JALR writeback.
- `instr_valid`, out, 1: `instr` is valid.
- `instr_ready`, in, 1: core retires `instr` this cycle.
- `pc_src`, in, 1: controller PCSrc; take the redirect. Sampled only at retire.
- `target_sel`, in, 1: 0 selects `branch_target` (PC+imm, used for branches and JAL); 1 selects `jalr_target` (rs1+imm).
- `branch_target`, in, XLEN: PC-relative target.
- `jalr_target`, in, XLEN: register-relative target.
- `fetch_fault`, out, 1: misaligned target detected. Present only when the feature is compiled in; see Configuration.

## Operation
- States: IDLE, REQ, WAIT, HOLD, and FAULT when the feature is compiled in.
- **IDLE:** entered on reset; `pc` = `RESET_PC`. Unconditionally moves to REQ on the next edge.
- **REQ:**
  - `imem_req_valid` = 1 and `imem_addr` = `pc`.
  - If `imem_req_ready` = 1, move to WAIT.
  - `pc` must not change while `imem_req_valid` is high.
- **WAIT:**
  - When `imem_rsp_valid` = 1, capture `imem_rdata` into `instr`, capture `pc` into `instr_pc`, and move to HOLD.
  - `imem_rsp_valid` is ignored in IDLE, REQ and HOLD. Stray responses are dropped.
- **HOLD:**
  - `instr_valid` = 1; `instr`, `instr_pc` and `instr_pc_plus4` are stable.
  - When `instr_ready` = 1, compute next PC and move to REQ.
  - Next PC = `pc_src` ? target : `pc` + 4.
  - Target = `target_sel` ? (`jalr_target` with bit 0 cleared) : `branch_target`.
  - If `instr_ready` = 0, the unit stays in HOLD indefinitely (stall).
- **Arithmetic:** all additions are modulo 2^XLEN. PC 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Only one request is outstanding at a time. A new request is never issued before the previous response has been captured.

## Timing
- **Reset values:**
  - `imem_req_valid` = 0, `imem_addr` = `RESET_PC`, `instr` = 0, `instr_pc` = `RESET_PC`, `instr_pc_plus4` = `RESET_PC` + 4, `instr_valid` = 0, `fetch_fault` = 0.
  - State = IDLE.
- **Reset assertion:** asynchronous. Outputs take their reset values immediately, including mid-WAIT. A pending response is discarded.
- **Reset release:** first edge after release goes IDLE→REQ, so `imem_req_valid` rises one cycle after release.
- **Zero-wait memory** (ready = 1, response one cycle after acceptance):
  - REQ (cycle N) → WAIT (N+1, response arrives) → HOLD (N+2, `instr_valid` = 1).
  - If retired in N+2, REQ is at N+3.
  - Throughput is therefore one instruction per 3 cycles.
- **Registered outputs:** all outputs are registered or derived directly from state. There is no combinational path from `pc_src`, `target_sel` or the targets to any output.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` **defined:**
  - At retire with `pc_src` = 1, if the selected target has bits [1:0] ≠ 0, move to FAULT instead of REQ.
  - `pc` still loads the target.
  - In FAULT: `fetch_fault` = 1, no requests are issued, `instr_valid` = 0. FAULT exits only on reset.
- `FETCH_MISALIGN_CHECK_EN` **undefined:**
  - No check is performed. The target is used as-is, with JALR bit 0 cleared.
  - `fetch_fault` is tied to 0. FAULT does not exist.

## Structure
- Shared package `fetch_pkg`: state enum (IDLE, REQ, WAIT, HOLD, FAULT), default `RESET_PC`, `XLEN`, and the constant `PC_INC` = 4.
- One sub-module, `fetch_next_pc`: combinational selection of the next PC (+4 vs target, JALR bit-0 clear, misalignment detect). It is instantiated once. The FSM and all registers remain in `fetch_unit`.

## Test plan
- **Reset and sequential fetch:** release `rst_n`; memory is zero-wait with `imem_rdata` = 32'h0000_0013 (NOP); `instr_ready` = 1 and `pc_src` = 0. Required: `imem_addr` sequence 0x0, 0x4, 0x8; `instr_valid` high every 3rd cycle; `instr_pc_plus4` = 0x4, 0x8, 0xC.
- **Stall:** hold `instr_ready` = 0 for 5 cycles in HOLD. Required: `instr` and `instr_pc` constant, no new `imem_req_valid`. One cycle after `instr_ready` = 1, a request appears at `pc` + 4.
- **Branch vs. JALR:**
  - At PC 0x10, retire with `pc_src` = 1, `target_sel` = 0, `branch_target` = 0x40. Required: next `imem_addr` = 0x40.
  - Then retire with `target_sel` = 1, `jalr_target` = 0x81. Required: next `imem_addr` = 0x80.
- **Backpressure and reset mid-WAIT:**
  - `imem_req_ready` low for 3 cycles. Required: `imem_addr` held.
  - Assert `rst_n` = 0 while in WAIT, then have `imem_rsp_valid` arrive. Required: response ignored, `instr_valid` = 0, and fetch restarts at `RESET_PC`.
- **Wrap-around:** `RESET_PC` = 32'hFFFF_FFFC, sequential retire. Required: next `imem_addr` = 0x0.
- **With `FETCH_MISALIGN_CHECK_EN`:** retire with `pc_src` = 1, `branch_target` = 0x42. Required: `fetch_fault` = 1 on the next cycle and no further `imem_req_valid` until reset.
